if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the IF/ID register. Holds the PC, a word-addressed instruction memory loaded by the debug unit, next-PC selection (sequential / redirect), stall and step gating, and HALT detection. Outputs PC+4 and the fetched instruction combinationally, so the IF/ID register captures them on the falling edge.

Parameters:
NB, 32, data/address width
IMEM_DEPTH, 256, instruction memory depth in 32-bit words (power of two)
RESET_PC, 32'h0000_0000, PC value after reset
HALT_INSTR, 32'hFFFF_FFFF, encoding that stops fetch

Ports:
i_clk  in  1  clock; all state updates on rising edge
i_reset  in  1  reset i_reset, synchronous, active-high
i_step  in  1  advance enable; tied 1 in continuous mode, one-cycle pulse in step mode
i_stall  in  1  hazard unit: hold PC
i_redirect  in  1  branch/jump taken, resolved in ID
i_redirect_pc  in  NB  branch/jump target byte address
i_imem_wr_en  in  1  debug loader write strobe
i_imem_wr_addr  in  NB  byte address of word written
i_imem_wr_data  in  NB  instruction word
o_pc  out  NB  current PC
o_pc4  out  NB  o_pc + 4, to IF/ID
o_instruction  out  NB  word at o_pc, to IF/ID
o_halt  out  1  HALT fetched; fetch frozen
o_fetch_count  out  NB  number of PC advances since reset

Behaviour:
- Reset (rising edge with i_reset=1): PC=RESET_PC, state=RUN, o_halt=0, o_fetch_count=0. Memory contents NOT cleared. Reset overrides every other input, including mid-halt.
- Memory: word index = PC[log2(IMEM_DEPTH)+1:2]; upper bits ignored (address wraps modulo depth). Read asynchronous: o_instruction follows array and PC combinationally. Write on rising edge when i_imem_wr_en=1, index from i_imem_wr_addr the same way; accepted in any state, including during reset. After write edge, reading same index returns new word.
- o_pc4 = PC + 4, modulo 2^NB (32'hFFFF_FFFC -> 0).
- State machine, evaluated on rising edge, priority top-down:
  RUN:
  - i_step=0: hold everything.
  - i_stall=1: hold PC and count (stall wins over redirect).
  - i_redirect=1: PC = {i_redirect_pc[NB-1:2], 2'b00}; count+1. Redirect is taken even if the current word is HALT, since HALT lies on the squashed path.
  - o_instruction == HALT_INSTR: state -> HALTED; PC held at HALT address; count unchanged.
  - else: PC = PC+4; count+1.
  HALTED: PC, count frozen; i_step, i_stall, i_redirect ignored; exit only via reset.
- o_halt = (state == HALTED), registered; asserts on the edge after HALT is consumed. o_instruction keeps presenting HALT_INSTR so downstream stages drain it.
- o_fetch_count wraps modulo 2^NB.
- Redirect must be held by its source until an edge with i_step=1; no internal pending latch.
- Latency: PC change visible on o_pc/o_pc4/o_instruction in the same cycle, after the rising edge; IF/ID captures on the following falling edge.

Decomposition:
- Shared package: NB, HALT_INSTR, NOP_INSTR (32'h0), state encoding (RUN=1'b0, HALTED=1'b1), IMEM address width function.
- Sub-module: instruction_memory (async read, sync write, depth param). PC/next-PC/FSM stay in if_stage.

Test Plan:
- Reset, load words 0x20010005, 0x20020007, HALT at byte addresses 0, 4, 8; continuous step -> PC 0, 4, 8 on successive edges, then o_halt=1, PC stays 8, o_fetch_count=2.
- i_stall=1 for 3 edges at PC=4 with i_redirect=1, target 0x40 -> PC remains 4, count unchanged; stall released -> PC=0x40 next edge.
- Redirect to 0x4E -> PC=0x4C (alignment forced). Redirect while o_instruction==HALT_INSTR -> PC=target, o_halt stays 0.
- Step mode: i_step low 5 edges -> PC frozen; single-cycle pulse -> PC advances exactly 4; count+1.
- PC wrap: IMEM_DEPTH=256, redirect to 0x400 -> fetches word index 0; redirect to 0xFFFFFFFC -> o_pc4=0.
- Reset asserted while HALTED -> PC=RESET_PC, o_halt=0, count=0, memory contents intact (word 0 still 0x20010005).

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, special
// instruction encodings, fetch state encoding and the IMEM index width helper.
package if_stage_pkg;

  localparam int NB = 32;

  localparam logic [NB-1:0] HALT_INSTR = 32'hFFFF_FFFF;
  localparam logic [NB-1:0] NOP_INSTR  = 32'h0000_0000;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  // Number of word-index bits needed for an instruction memory of 'depth' words.
  function automatic int imem_aw(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Debug-loader write bus into the instruction memory. The loader is the
// master; the fetch stage receives the writes as slave.
interface if_stage_if;
  import if_stage_pkg::*;

  logic          imem_wr_en;
  logic [NB-1:0] imem_wr_addr;
  logic [NB-1:0] imem_wr_data;

  modport master (
    output imem_wr_en,
    output imem_wr_addr,
    output imem_wr_data
  );

  modport slave (
    input imem_wr_en,
    input imem_wr_addr,
    input imem_wr_data
  );

endinterface

// File: rtl/if_stage_instruction_memory.sv
// Word-addressed instruction memory: asynchronous read, synchronous write.
// Contents are deliberately not reset so a loaded program survives a core reset.
module instruction_memory
  import if_stage_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = imem_aw(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_idx,
  input  logic [NB-1:0] wr_data,
  input  logic [AW-1:0] rd_idx,
  output logic [NB-1:0] rd_data
);

  logic [NB-1:0] mem [DEPTH];

  // Loader writes land on the rising edge, in any fetch state.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection (sequential or
// redirect), stall/step gating, HALT detection and fetch counting.
//
// state  | meaning
// -------+-------------------------------------------------------------
// RUN    | fetching; PC advances on stepped, unstalled edges
// HALTED | HALT word consumed; PC and count frozen until reset
module if_stage
  import if_stage_pkg::*;
#(
  parameter int            IMEM_DEPTH = 256,
  parameter logic [NB-1:0] RESET_PC   = 32'h0000_0000
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_step,
  input  logic          i_stall,
  input  logic          i_redirect,
  input  logic [NB-1:0] i_redirect_pc,
  if_stage_if.slave     imem_wr,
  output logic [NB-1:0] o_pc,
  output logic [NB-1:0] o_pc4,
  output logic [NB-1:0] o_instruction,
  output logic          o_halt,
  output logic [NB-1:0] o_fetch_count
);

  localparam int            AW      = imem_aw(IMEM_DEPTH);
  localparam logic [NB-1:0] PC_INC  = 4;
  localparam logic [NB-1:0] CNT_INC = 1;

  fetch_state_t  state_q, state_d;
  logic [NB-1:0] pc_q, pc_d;
  logic [NB-1:0] count_q, count_d;
  logic [NB-1:0] instr;

  // Address bits above the memory depth and the byte offset are ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{imem_wr.imem_wr_addr[NB-1:AW+2],
                              imem_wr.imem_wr_addr[1:0],
                              i_redirect_pc[1:0]};

  instruction_memory #(
    .DEPTH (IMEM_DEPTH),
    .AW    (AW)
  ) u_imem (
    .clk     (i_clk),
    .wr_en   (imem_wr.imem_wr_en),
    .wr_idx  (imem_wr.imem_wr_addr[AW+1:2]),
    .wr_data (imem_wr.imem_wr_data),
    .rd_idx  (pc_q[AW+1:2]),
    .rd_data (instr)
  );

  // Next-state / next-PC selection; stall beats redirect, redirect beats HALT
  // because a HALT behind a taken branch is on the squashed path.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    if (state_q == RUN && i_step && !i_stall) begin
      if (i_redirect) begin
        pc_d    = {i_redirect_pc[NB-1:2], 2'b00};
        count_d = count_q + CNT_INC;
      end else if (instr == HALT_INSTR) begin
        state_d = HALTED;
      end else begin
        pc_d    = pc_q + PC_INC;
        count_d = count_q + CNT_INC;
      end
    end
  end

  // State, PC and fetch-count registers; reset overrides everything.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
    end
  end

  assign o_pc          = pc_q;
  assign o_pc4         = pc_q + PC_INC;
  assign o_instruction = instr;
  assign o_halt        = (state_q == HALTED);
  assign o_fetch_count = count_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for the instruction-fetch stage.
module tb_if_stage;
  import if_stage_pkg::*;

  logic          clk;
  logic          reset;
  logic          step;
  logic          stall;
  logic          redirect;
  logic [NB-1:0] redirect_pc;
  logic [NB-1:0] pc, pc4, instruction, fetch_count;
  logic          halt;

  int checks = 0;
  int errors = 0;

  if_stage_if bus ();

  if_stage #(
    .IMEM_DEPTH (256),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_step        (step),
    .i_stall       (stall),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .imem_wr       (bus.slave),
    .o_pc          (pc),
    .o_pc4         (pc4),
    .o_instruction (instruction),
    .o_halt        (halt),
    .o_fetch_count (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
    bus.imem_wr_en   = 1'b1;
    bus.imem_wr_addr = addr;
    bus.imem_wr_data = data;
    tick();
    bus.imem_wr_en   = 1'b0;
  endtask

  initial begin
    reset            = 1'b1;
    step             = 1'b0;
    stall            = 1'b0;
    redirect         = 1'b0;
    redirect_pc      = '0;
    bus.imem_wr_en   = 1'b0;
    bus.imem_wr_addr = '0;
    bus.imem_wr_data = '0;

    // Program load while reset is held
    write_word(32'h0000_0000, 32'h2001_0005);
    write_word(32'h0000_0004, 32'h2002_0007);
    write_word(32'h0000_0008, HALT_INSTR);
    write_word(32'h0000_0040, 32'hAAAA_0001);
    write_word(32'h0000_0044, 32'hAAAA_0002);
    write_word(32'h0000_004C, HALT_INSTR);
    write_word(32'hFFFF_FFFC, 32'hCCCC_0255);
    tick();

    check("reset_pc",    pc,           32'h0);
    check("reset_pc4",   pc4,          32'h4);
    check("reset_halt",  {31'b0, halt}, 32'h0);
    check("reset_count", fetch_count,  32'h0);
    check("reset_instr", instruction,  32'h2001_0005);

    // Continuous run to HALT
    reset = 1'b0;
    step  = 1'b1;
    tick();
    check("run_pc1",    pc,          32'h4);
    check("run_instr1", instruction, 32'h2002_0007);
    check("run_cnt1",   fetch_count, 32'h1);
    tick();
    check("run_pc2",    pc,           32'h8);
    check("run_instr2", instruction,  HALT_INSTR);
    check("run_halt2",  {31'b0, halt}, 32'h0);
    tick();
    check("halt_set",   {31'b0, halt}, 32'h1);
    check("halt_pc",    pc,           32'h8);
    check("halt_cnt",   fetch_count,  32'h2);
    check("halt_instr", instruction,  HALT_INSTR);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0040;
    tick();
    tick();
    check("halt_ign_redir_pc",   pc,           32'h8);
    check("halt_ign_redir_halt", {31'b0, halt}, 32'h1);
    check("halt_ign_redir_cnt",  fetch_count,  32'h2);
    redirect = 1'b0;

    // Reset out of HALTED
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_pc",    pc,           32'h0);
    check("rst2_halt",  {31'b0, halt}, 32'h0);
    check("rst2_cnt",   fetch_count,  32'h0);
    check("rst2_instr", instruction,  32'h2001_0005);

    // Stall beats redirect
    tick();
    check("pre_stall_pc", pc, 32'h4);
    stall       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0040;
    tick();
    tick();
    tick();
    check("stall_pc",  pc,          32'h4);
    check("stall_cnt", fetch_count, 32'h1);
    stall = 1'b0;
    tick();
    check("unstall_pc",    pc,          32'h40);
    check("unstall_cnt",   fetch_count, 32'h2);
    check("unstall_instr", instruction, 32'hAAAA_0001);

    // Misaligned redirect target, then redirect over a HALT word
    redirect_pc = 32'h0000_004E;
    tick();
    check("align_pc",    pc,           32'h4C);
    check("align_instr", instruction,  HALT_INSTR);
    check("align_cnt",   fetch_count,  32'h3);
    redirect_pc = 32'h0000_0040;
    tick();
    check("redir_over_halt_pc",   pc,           32'h40);
    check("redir_over_halt_halt", {31'b0, halt}, 32'h0);
    check("redir_over_halt_cnt",  fetch_count,  32'h4);
    redirect = 1'b0;

    // Step mode
    step = 1'b0;
    repeat (5) tick();
    check("step_frozen_pc",  pc,          32'h40);
    check("step_frozen_cnt", fetch_count, 32'h4);
    step = 1'b1;
    tick();
    step = 1'b0;
    check("step_pulse_pc",  pc,          32'h44);
    check("step_pulse_cnt", fetch_count, 32'h5);
    tick();
    tick();
    check("step_after_pc", pc, 32'h44);

    // Address wrap and PC+4 overflow
    step        = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0400;
    tick();
    check("wrap_pc",    pc,          32'h400);
    check("wrap_instr", instruction, 32'h2001_0005);
    check("wrap_cnt",   fetch_count, 32'h6);
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    check("top_pc",    pc,          32'hFFFF_FFFC);
    check("top_pc4",   pc4,         32'h0);
    check("top_instr", instruction, 32'hCCCC_0255);
    redirect = 1'b0;
    tick();
    check("roll_pc",  pc,          32'h0);
    check("roll_cnt", fetch_count, 32'h8);

    // Run into HALT again, then reset mid-halt with a write during reset
    tick();
    tick();
    tick();
    check("halt2_set", {31'b0, halt}, 32'h1);
    check("halt2_pc",  pc,           32'h8);
    check("halt2_cnt", fetch_count,  32'hA);
    reset = 1'b1;
    tick();
    check("rst3_pc",    pc,           32'h0);
    check("rst3_halt",  {31'b0, halt}, 32'h0);
    check("rst3_cnt",   fetch_count,  32'h0);
    check("rst3_instr", instruction,  32'h2001_0005);
    write_word(32'h0000_0400, 32'h1234_5678);
    check("wr_in_reset_instr", instruction, 32'h1234_5678);
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
